// File: rtl/apb_wdt.sv
// APB watchdog: loadable down-counter with warn interrupt on first timeout
// and a fixed-width reset request on a second consecutive timeout.
module apb_wdt #(
    parameter int          CNT_W     = 32,
    parameter int          PRESC     = 8,
    parameter int          RST_PULSE = 16,
    parameter logic [31:0] KEY       = 32'hA5A5_5A5A
) (
    input  logic        apb_pclk,
    input  logic        apb_prst,
    input  logic        apb_psel,
    input  logic [4:0]  apb_paddr,
    input  logic        apb_pwrite,
    input  logic        apb_penable,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        wdt_int_o,
    output logic        wdt_rst_o
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int QW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);
    localparam logic [QW-1:0] PULSE_MAX = QW'(RST_PULSE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WARN = 2'd2;
    localparam logic [1:0] S_BITE = 2'd3;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_LOAD   = 3'd1;
    localparam logic [2:0] A_VALUE  = 3'd2;
    localparam logic [2:0] A_FEED   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    typedef struct packed {
        logic lock;
        logic int_en;
        logic rst_en;
        logic en;
    } ctrl_t;

    ctrl_t            ctrl;
    logic [CNT_W-1:0] load_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    presc_q;
    logic [QW-1:0]    pulse_q;
    logic [1:0]       state;
    logic             int_flag;
    logic             rst_flag;

    logic       wr_stb;
    logic [2:0] reg_sel;
    logic       ctrl_wr, load_wr, feed_wr, stat_wr;
    logic       en_rise, en_fall;
    logic       active, tick, feed, timeout;
    logic [1:0] unused_addr;

    assign unused_addr = apb_paddr[1:0];
    assign wr_stb  = apb_psel & apb_penable & apb_pwrite;
    assign reg_sel = apb_paddr[4:2];

    assign ctrl_wr = wr_stb & (reg_sel == A_CTRL) & ~ctrl.lock;
    assign load_wr = wr_stb & (reg_sel == A_LOAD) & ~ctrl.lock;
    assign feed_wr = wr_stb & (reg_sel == A_FEED) & (apb_pwdata == KEY);
    assign stat_wr = wr_stb & (reg_sel == A_STATUS);

    assign en_rise = ctrl_wr &  apb_pwdata[0] & ~ctrl.en;
    assign en_fall = ctrl_wr & ~apb_pwdata[0] &  ctrl.en;

    assign active  = (state == S_RUN) | (state == S_WARN);
    assign tick    = (presc_q == PRESC_MAX);
    assign feed    = feed_wr & active;
    // A feed or disable in the same cycle suppresses the timeout and its flag.
    assign timeout = active & tick & (cnt_q == '0) & ~feed & ~en_fall;

    always_ff @(posedge apb_pclk) begin
        if (apb_prst) begin
            ctrl      <= '0;
            load_q    <= '0;
            cnt_q     <= '0;
            presc_q   <= '0;
            pulse_q   <= '0;
            state     <= S_IDLE;
            int_flag  <= 1'b0;
            rst_flag  <= 1'b0;
            wdt_rst_o <= 1'b0;
        end else begin
            if (ctrl_wr)
                ctrl <= ctrl_t'(apb_pwdata[3:0]);
            if (load_wr)
                load_q <= apb_pwdata[CNT_W-1:0];

            // W1C loses to a same-cycle set
            int_flag <= (int_flag & ~(stat_wr & apb_pwdata[0])) | (timeout & (state == S_RUN));
            rst_flag <= (rst_flag & ~(stat_wr & apb_pwdata[1])) | (timeout & (state == S_WARN));

            case (state)
                S_IDLE: begin
                    presc_q <= '0;
                    if (en_rise) begin
                        cnt_q <= load_q;
                        state <= S_RUN;
                    end
                end
                S_RUN, S_WARN: begin
                    if (en_fall) begin
                        state <= S_IDLE;
                    end else if (feed) begin
                        cnt_q   <= load_q;
                        presc_q <= '0;
                        state   <= S_RUN;
                    end else if (tick) begin
                        presc_q <= '0;
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            cnt_q <= load_q;
                            if (state == S_RUN) begin
                                state <= S_WARN;
                            end else if (ctrl.rst_en) begin
                                state     <= S_BITE;
                                wdt_rst_o <= 1'b1;
                                pulse_q   <= '0;
                            end else begin
                                state <= S_RUN;
                            end
                        end
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                default: begin
                    // Pulse always completes; counter and prescaler stay frozen.
                    pulse_q <= pulse_q + 1'b1;
                    if (pulse_q == PULSE_MAX) begin
                        wdt_rst_o <= 1'b0;
                        state     <= S_RUN;
                    end
                end
            endcase
        end
    end

    always_comb begin
        apb_prdata = '0;
        if (apb_psel) begin
            case (reg_sel)
                A_CTRL:   apb_prdata[3:0]       = ctrl;
                A_LOAD:   apb_prdata[CNT_W-1:0] = load_q;
                A_VALUE:  apb_prdata[CNT_W-1:0] = cnt_q;
                A_STATUS: apb_prdata[1:0]       = {rst_flag, int_flag};
                default:  apb_prdata = '0;
            endcase
        end
    end

    assign wdt_int_o = int_flag & ctrl.int_en;

endmodule

// File: tb/tb_apb_wdt.sv
// Scoreboard bench for apb_wdt: drivers queue expectations tagged with the
// cycle they apply to; a negedge monitor pops and compares them.
module tb_apb_wdt;

    logic        apb_pclk = 1'b0;
    logic        apb_prst;
    logic        apb_psel;
    logic [4:0]  apb_paddr;
    logic        apb_pwrite;
    logic        apb_penable;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        wdt_int_o;
    logic        wdt_rst_o;

    localparam logic [31:0] KEY = 32'hA5A5_5A5A;
    localparam int K_RD = 0, K_INT = 1, K_RST = 2;

    apb_wdt #(.CNT_W(32), .PRESC(1), .RST_PULSE(16), .KEY(KEY)) dut (
        .apb_pclk(apb_pclk), .apb_prst(apb_prst), .apb_psel(apb_psel),
        .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite), .apb_penable(apb_penable),
        .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
        .wdt_int_o(wdt_int_o), .wdt_rst_o(wdt_rst_o)
    );

    always #5 apb_pclk = ~apb_pclk;

    int cyc = 0;
    always @(posedge apb_pclk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        int          cyc;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string n, input int k, input logic [31:0] e);
        chk_t c;
        c.name = n; c.kind = k; c.exp = e; c.cyc = cyc;
        sb.push_back(c);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge apb_pclk);
        #1;
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        apb_psel = 1'b1; apb_pwrite = 1'b1; apb_penable = 1'b0;
        apb_paddr = a; apb_pwdata = d;
        tick(1);
        apb_penable = 1'b1;
        tick(1);
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, input logic [31:0] e, input string n);
        apb_psel = 1'b1; apb_pwrite = 1'b0; apb_penable = 1'b0; apb_paddr = a;
        tick(1);
        apb_penable = 1'b1;
        push(n, K_RD, e);
        tick(1);
        apb_psel = 1'b0; apb_penable = 1'b0;
    endtask

    // One-cycle select without penable: prdata is combinational on psel.
    task automatic peek(input logic [4:0] a, input logic [31:0] e, input string n);
        apb_psel = 1'b1; apb_pwrite = 1'b0; apb_penable = 1'b0; apb_paddr = a;
        push(n, K_RD, e);
        tick(1);
        apb_psel = 1'b0;
    endtask

    task automatic pin(input int k, input logic e, input string n);
        push(n, k, {31'b0, e});
    endtask

    chk_t        mc;
    logic [31:0] act;
    always @(negedge apb_pclk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mc = sb.pop_front();
            case (mc.kind)
                K_INT:   act = {31'b0, wdt_int_o};
                K_RST:   act = {31'b0, wdt_rst_o};
                default: act = apb_prdata;
            endcase
            checks++;
            if (mc.cyc != cyc) begin
                errors++;
                $display("FAIL %s: sampled late at cycle %0d, wanted cycle %0d", mc.name, cyc, mc.cyc);
            end else if (act !== mc.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", mc.name, act, mc.exp, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        apb_prst = 1'b1; apb_psel = 1'b0; apb_paddr = '0; apb_pwrite = 1'b0;
        apb_penable = 1'b0; apb_pwdata = '0;
        tick(2);
        apb_prst = 1'b0;

        // reset state
        pin(K_INT, 1'b0, "rst_int");
        pin(K_RST, 1'b0, "rst_rst");
        peek(5'h00, 32'h0, "rst_ctrl");
        peek(5'h04, 32'h0, "rst_load");
        peek(5'h08, 32'h0, "rst_value");
        peek(5'h10, 32'h0, "rst_status");

        // 1: load and first timeout
        apb_write(5'h04, 32'd10);
        apb_write(5'h00, 32'h5);
        for (int k = 0; k <= 10; k++) begin
            if (k == 10) pin(K_INT, 1'b0, "s1_int_before");
            peek(5'h08, 32'(10 - k), "s1_value");
        end
        pin(K_INT, 1'b1, "s1_int_after");
        peek(5'h08, 32'd10, "s1_reload");

        // 2: second timeout -> 16-clock bite, then resume from LOAD
        apb_write(5'h00, 32'h7);
        peek(5'h08, 32'd7, "s2_warn_value");
        tick(6);
        pin(K_RST, 1'b0, "s2_rst_pre");
        peek(5'h08, 32'd0, "s2_value_zero");
        pin(K_RST, 1'b1, "s2_rst_rise");
        peek(5'h10, 32'h3, "s2_status");
        for (int k = 0; k < 15; k++) begin
            pin(K_RST, 1'b1, "s2_rst_hold");
            peek(5'h08, 32'd10, "s2_frozen");
        end
        pin(K_RST, 1'b0, "s2_rst_fall");
        pin(K_INT, 1'b1, "s2_int");
        peek(5'h08, 32'd10, "s2_resume");
        peek(5'h08, 32'd9, "s2_count");

        // 3: periodic feeds keep it quiet; a bad key does not feed
        apb_write(5'h10, 32'h3);
        pin(K_INT, 1'b0, "s3_int_clr");
        for (int k = 0; k < 25; k++) begin
            apb_write(5'h0C, KEY);
            pin(K_RST, 1'b0, "s3_rst");
            pin(K_INT, 1'b0, "s3_int");
            tick(6);
        end
        peek(5'h10, 32'h0, "s3_status");
        apb_write(5'h0C, 32'h1234_5678);
        peek(5'h08, 32'd1, "s3_bad_value1");
        pin(K_INT, 1'b0, "s3_bad_int0");
        peek(5'h08, 32'd0, "s3_bad_value0");
        pin(K_INT, 1'b1, "s3_bad_int1");
        peek(5'h10, 32'h1, "s3_bad_status");

        // 4: feed on the exact timeout tick, then feed out of WARN
        apb_write(5'h0C, KEY);
        apb_write(5'h10, 32'h1);
        peek(5'h10, 32'h0, "s4_clear");
        tick(6);
        apb_write(5'h0C, KEY);
        peek(5'h08, 32'd10, "s4_race_value");
        pin(K_INT, 1'b0, "s4_race_int");
        peek(5'h10, 32'h0, "s4_race_status");
        tick(9);
        pin(K_INT, 1'b1, "s4_warn_int");
        peek(5'h10, 32'h1, "s4_warn_status");
        apb_write(5'h0C, KEY);
        pin(K_INT, 1'b1, "s4_feed_int");
        peek(5'h10, 32'h1, "s4_feed_status");
        apb_write(5'h10, 32'h1);
        pin(K_INT, 1'b0, "s4_w1c_int");
        peek(5'h10, 32'h0, "s4_w1c_status");
        tick(7);
        peek(5'h10, 32'h1, "s4_back_in_run");

        // 5: lock
        apb_write(5'h00, 32'hD);
        apb_write(5'h00, 32'h0);
        apb_write(5'h04, 32'd3);
        apb_read(5'h00, 32'hD, "s5_ctrl_locked");
        apb_read(5'h04, 32'd10, "s5_load_locked");
        pin(K_RST, 1'b0, "s5_no_bite");
        peek(5'h08, 32'd10, "s5_reload");
        peek(5'h08, 32'd9, "s5_running");
        pin(K_INT, 1'b1, "s5_int");
        peek(5'h10, 32'h3, "s5_status");
        apb_read(5'h14, 32'h0, "s5_unmapped");
        apb_read(5'h0C, 32'h0, "s5_feed_read");
        apb_prst = 1'b1;
        tick(1);
        apb_prst = 1'b0;
        peek(5'h00, 32'h0, "s5_rst_ctrl");
        peek(5'h04, 32'h0, "s5_rst_load");
        peek(5'h08, 32'h0, "s5_rst_value");
        peek(5'h10, 32'h0, "s5_rst_status");
        pin(K_INT, 1'b0, "s5_rst_int");
        // LOAD=0: timeout on every tick, lock is gone
        apb_write(5'h00, 32'h1);
        peek(5'h08, 32'h0, "s5_load0_value");
        peek(5'h10, 32'h1, "s5_load0_first");
        pin(K_INT, 1'b0, "s5_load0_int_masked");
        peek(5'h10, 32'h3, "s5_load0_second");
        pin(K_RST, 1'b0, "s5_load0_no_bite");
        peek(5'h00, 32'h1, "s5_unlocked");

        // 6: reset during bite
        apb_prst = 1'b1;
        tick(1);
        apb_prst = 1'b0;
        apb_write(5'h04, 32'd2);
        apb_write(5'h00, 32'h3);
        tick(6);
        pin(K_RST, 1'b1, "s6_bite");
        peek(5'h10, 32'h3, "s6_status");
        tick(4);
        pin(K_RST, 1'b1, "s6_bite_mid");
        apb_prst = 1'b1;
        tick(1);
        apb_prst = 1'b0;
        pin(K_RST, 1'b0, "s6_abort");
        peek(5'h00, 32'h0, "s6_ctrl");
        peek(5'h04, 32'h0, "s6_load");
        peek(5'h08, 32'h0, "s6_value");
        peek(5'h10, 32'h0, "s6_status0");
        tick(3);
        pin(K_RST, 1'b0, "s6_idle_rst");
        peek(5'h08, 32'h0, "s6_idle_value");
        apb_write(5'h04, 32'd5);
        apb_paddr = 5'h04;
        push("s6_nosel", K_RD, 32'h0);
        tick(1);
        peek(5'h04, 32'd5, "s6_sel");

        tick(2);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_wdt.md
Name: apb_wdt

Overview:
- APB slave watchdog timer on the CPU's spare APB port 7, clocked by the 8 MHz system clock.
- Counts down from a software-loaded value and must be fed with a key write.
- First timeout raises an interrupt to the interrupt controller and reloads the counter.
- Second consecutive timeout without a feed issues a fixed-width system-reset pulse.
- The APB port is zero-wait: the master's ack is its own penable.

Parameters:
- CNT_W, 32: counter/LOAD width, 1..32.
- PRESC, 8: one count tick every PRESC clocks; 1 = every clock.
- RST_PULSE, 16: wdt_rst_o high time in clocks, ≥1.
- KEY, 32'hA5A5_5A5A: feed key.

Ports:
- apb_pclk  in  1  system clock.
- apb_prst  in  1  synchronous active-high reset.
- apb_psel  in  1  APB select.
- apb_paddr  in  5  byte address, bits [1:0] ignored.
- apb_pwrite  in  1  write strobe.
- apb_penable  in  1  access phase.
- apb_pwdata  in  32  write data.
- apb_prdata  out  32  read data.
- wdt_int_o  out  1  level interrupt.
- wdt_rst_o  out  1  reset request pulse.

Behaviour:
Registers:
- 0x00 CTRL RW: bit0 EN, bit1 RST_EN, bit2 INT_EN, bit3 LOCK (set-only).
- 0x04 LOAD RW: [CNT_W-1:0].
- 0x08 VALUE RO: current counter.
- 0x0C FEED WO: writing KEY is a feed; any other value is ignored.
- 0x10 STATUS: bit0 INT_FLAG, bit1 RST_FLAG; write-1-to-clear.
- Unmapped addresses: read 0, writes ignored.

APB:
- Write commits on the clock where psel & penable & pwrite are all high; exactly one commit per access.
- apb_prdata is combinational from the address and registered state whenever psel=1, and 0 when psel=0. It must be valid in the access cycle.

Reset (apb_prst=1 at a clock edge):
- All registers, counter and prescaler clear to 0.
- State goes to IDLE.
- wdt_int_o=0, wdt_rst_o=0.
- Reset aborts any in-progress pulse immediately.

LOCK:
- Once set, writes to CTRL and LOAD are ignored until reset.
- FEED and STATUS writes still work.

Prescaler:
- Counts 0..PRESC-1 while in RUN or WARN.
- tick = prescaler==PRESC-1; the prescaler wraps to 0 on tick.
- The prescaler clears on any feed, on entering RUN from IDLE, and in IDLE.

FSM:
- IDLE:
  - Counter holds its value.
  - A CTRL write with EN 0→1: next cycle counter=LOAD, go to RUN.
- RUN:
  - On tick with VALUE≠0: VALUE-=1.
  - On tick with VALUE==0 (first timeout): set INT_FLAG, counter=LOAD, go to WARN.
- WARN:
  - Counts identically to RUN.
  - On tick with VALUE==0 (second timeout): set RST_FLAG, counter=LOAD, prescaler=0.
  - Then go to BITE if RST_EN=1, otherwise go to RUN.
- BITE:
  - wdt_rst_o=1 for exactly RST_PULSE clocks, counted by an internal pulse counter.
  - Counter and prescaler are frozen.
  - Then go to RUN.
  - Feed, EN clear and CTRL writes are still accepted, but the pulse always runs to completion.

Feed (RUN or WARN):
- Counter=LOAD, prescaler=0, go to RUN.
- INT_FLAG is not cleared by a feed.
- A feed in IDLE is ignored.

EN cleared by a CTRL write (not locked):
- From RUN or WARN, go to IDLE next cycle.
- Counter and flags hold.

Simultaneous events, same cycle:
- Feed vs. timeout tick: the feed wins; no flag is set.
- STATUS W1C vs. flag set: the set wins.
- A LOAD write takes effect at the next reload only. It does not modify the running counter.

Boundaries:
- LOAD=0: timeout on the first tick after load.
- LOAD written with a value wider than CNT_W: truncated.
- VALUE never wraps below 0.

Outputs:
- wdt_int_o = INT_FLAG & INT_EN, driven from registered values, so no glitches.
- wdt_rst_o is registered.
- Latency from the timeout tick to wdt_int_o high: 1 clock.

Test Plan:
1. Reset, then PRESC=1, LOAD=10, CTRL=0x5 (EN, INT_EN):
   - VALUE reads 10 the cycle after the write commits, then decrements each clock.
   - The first timeout occurs 11 ticks after load.
   - wdt_int_o rises 1 clock after that, and VALUE reads 10 again.
2. Continue from scenario 1 with no feed, CTRL=0x7:
   - 11 ticks after entering WARN, RST_FLAG=1.
   - wdt_rst_o is high for exactly 16 clocks, then drops.
   - Counting resumes from 10.
3. Run with LOAD=10 and write KEY to 0x0C every 8 clocks for 200 clocks:
   - No INT_FLAG and no wdt_rst_o.
   - Writing 0x1234_5678 to 0x0C instead: timeout still occurs on schedule.
4. Feed write landing on the exact tick where VALUE==0:
   - VALUE reloads to LOAD and INT_FLAG stays 0.
   - In WARN, the feed returns to RUN and INT_FLAG stays 1 until 0x1 is written to 0x10, after which wdt_int_o=0.
5. Write CTRL=0xD (EN, INT_EN, LOCK), then CTRL=0x0 and LOAD=3:
   - CTRL still reads 0xD and LOAD is unchanged.
   - The watchdog keeps running.
   - Asserting apb_prst for 1 clock clears everything, including LOCK.
6. Assert apb_prst in the middle of the BITE pulse:
   - wdt_rst_o goes 0 at that edge.
   - State is IDLE, all registers read 0, and psel=0 gives prdata=0.
